uart_rx_pkt_parser: RTL and testbench

Downstream consumer of the UART receiver's byte output (`done` strobe + `dout[7:0]`). It assembles framed packets of the form SOF, LEN, payload[LEN], CSUM. It checks length and XOR checksum, and enforces an inter-byte timeout. Only verified payloads are streamed out on a valid/ready byte interface with a last marker; malformed frames are dropped and reported with an error pulse and code.

---
 rtl/uart_pkt_pkg.sv | 21 ++
 rtl/uart_pkt_timeout.sv | 25 ++
 rtl/uart_rx_pkt_parser.sv | 139 +++++++++++++
 tb/tb_uart_rx_pkt_parser.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet parser: FSM states, error codes, default SOF.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    S_SOF,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    ERR_LEN     = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVERRUN = 2'd3
  } err_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte watchdog: counts idle clocks while enabled, expires on the last allowed idle clock.
module uart_pkt_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] tcnt_q;

  // A byte in the expiry cycle clears the count, so it always beats the timeout.
  assign expire_o = (TIMEOUT_CLKS != 0) && en_i && !clr_i && (tcnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || clr_i || expire_o) tcnt_q <= '0;
    else                                     tcnt_q <= tcnt_q + TW'(1);
  end

endmodule

// File: rtl/uart_rx_pkt_parser.sv
// Assembles SOF/LEN/payload/CSUM frames from UART bytes, verifies them and
// streams good payloads out on a valid/ready interface.
module uart_rx_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_done_i,
  input  logic [7:0] rx_data_i,
  output logic       m_valid_o,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  input  logic       m_ready_i,
  output logic       pkt_ok_o,
  output logic       pkt_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e        state_q;
  err_e          err_code_q;
  logic [LW-1:0] len_q, wr_idx_q, rd_idx_q;
  logic [7:0]    csum_q, m_data_q;
  logic          m_valid_q, m_last_q, pkt_ok_q, pkt_err_q;
  logic [7:0]    pbuf_q [MAX_LEN];

  logic          tmo_en, expire;
  logic [LW-1:0] len_m1, rd_nxt;

  assign tmo_en = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign len_m1 = len_q - LW'(1);
  assign rd_nxt = rd_idx_q + LW'(1);

  uart_pkt_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (tmo_en),
    .clr_i    (rx_done_i),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i) begin
    if (state_q == S_PAYLOAD && rx_done_i) pbuf_q[wr_idx_q[IW-1:0]] <= rx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_SOF;
      err_code_q <= ERR_LEN;
      len_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      csum_q     <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      pkt_ok_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      case (state_q)
        S_SOF: if (rx_done_i && rx_data_i == SOF_BYTE) state_q <= S_LEN;
        S_LEN: if (rx_done_i) begin
          // Full 8-bit compare so oversize lengths cannot alias after truncation.
          if (rx_data_i == 8'd0 || {24'd0, rx_data_i} > MAX_LEN) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_LEN;
            state_q    <= S_SOF;
          end else begin
            len_q    <= rx_data_i[LW-1:0];
            wr_idx_q <= '0;
            csum_q   <= rx_data_i;
            state_q  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (rx_done_i) begin
          csum_q   <= csum_q ^ rx_data_i;
          wr_idx_q <= wr_idx_q + LW'(1);
          if (wr_idx_q == len_m1) state_q <= S_CSUM;
        end
        S_CSUM: if (rx_done_i) begin
          if (rx_data_i == csum_q) begin
            pkt_ok_q  <= 1'b1;
            rd_idx_q  <= '0;
            m_valid_q <= 1'b1;
            m_data_q  <= pbuf_q[0];
            m_last_q  <= (len_q == LW'(1));
            state_q   <= S_OUT;
          end else begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_CSUM;
            state_q    <= S_SOF;
          end
        end
        S_OUT: begin
          if (rx_done_i) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= ERR_OVERRUN;
          end
          if (m_valid_q && m_ready_i) begin
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              state_q   <= S_SOF;
            end else begin
              rd_idx_q <= rd_nxt;
              m_data_q <= pbuf_q[rd_nxt[IW-1:0]];
              m_last_q <= (rd_nxt == len_m1);
            end
          end
        end
        default: state_q <= S_SOF;
      endcase
      // expire is never set together with rx_done, so it cannot clash with the case above.
      if (expire) begin
        pkt_err_q  <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= S_SOF;
      end
    end
  end

  assign m_valid_o  = m_valid_q;
  assign m_data_o   = m_data_q;
  assign m_last_o   = m_last_q;
  assign pkt_ok_o   = pkt_ok_q;
  assign pkt_err_o  = pkt_err_q;
  assign err_code_o = err_code_q;
  assign busy_o     = (state_q != S_SOF);

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Scoreboard bench: stimulus pushes expected beats/events, a negedge monitor pops and compares.
module tb_uart_rx_pkt_parser;
  localparam int MAXL = 16;
  localparam int TMO  = 100;

  logic       clk = 1'b0, rst = 1'b1, rx_done = 1'b0, m_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       m_valid, m_last, pkt_ok, pkt_err, busy;
  logic [7:0] m_data;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_rx_pkt_parser #(.MAX_LEN(MAXL), .SOF_BYTE(8'hA5), .TIMEOUT_CLKS(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rx_done_i(rx_done), .rx_data_i(rx_data),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_last_o(m_last), .m_ready_i(m_ready),
    .pkt_ok_o(pkt_ok), .pkt_err_o(pkt_err), .err_code_o(err_code), .busy_o(busy)
  );

  int total = 0, bad = 0;
  logic [8:0] exp_beats[$];  // {last, data}
  int         exp_ev[$];     // -1 = pkt_ok, 0..3 = pkt_err with that code
  logic [7:0] fq[$];
  int         rdy_mode = 1;  // 0 random, 1 always ready, 2 alternate

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_ready = ($urandom_range(0, 99) < 65);
      2:       m_ready = ~m_ready;
      default: m_ready = 1'b1;
    endcase
  end

  initial begin
    logic       stall;
    logic [8:0] sv, e;
    int         ee;
    stall = 1'b0;
    sv = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (pkt_ok && pkt_err) chk("ok_err_same_cycle", 1, 0);
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_hold", {m_last, m_data}, sv);
      end
      if (m_valid && m_ready) begin
        if (exp_beats.size() == 0) chk("unexpected_beat", {m_last, m_data}, -1);
        else begin
          e = exp_beats.pop_front();
          chk("beat", {m_last, m_data}, e);
        end
      end
      if (pkt_ok || pkt_err) begin
        if (exp_ev.size() == 0) chk("unexpected_event", pkt_ok ? -1 : int'(err_code), -9);
        else begin
          ee = exp_ev.pop_front();
          chk("event", pkt_ok ? -1 : int'(err_code), ee);
        end
      end
      stall = m_valid && !m_ready;
      sv    = {m_last, m_data};
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_fq(input int maxgap);
    for (int i = 0; i < fq.size(); i++) begin
      send_byte(fq[i]);
      if (maxgap > 0 && i < fq.size() - 1) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_beats.size() != 0 || exp_ev.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) chk("drain_timeout", exp_beats.size() + exp_ev.size(), 0);
    idle(2);
  endtask

  // Builds a frame with a random payload of length l; bad_csum corrupts the checksum byte.
  task automatic build_frame(input int l, input bit bad_csum);
    logic [7:0] cs, p;
    cs = 8'(l);
    fq = {8'hA5, 8'(l)};
    for (int i = 0; i < l; i++) begin
      p = 8'($urandom_range(0, 255));
      cs ^= p;
      fq.push_back(p);
      if (!bad_csum) exp_beats.push_back({(i == l - 1), p});
    end
    if (bad_csum) fq.push_back(cs ^ 8'($urandom_range(1, 255)));
    else          fq.push_back(cs);
    exp_ev.push_back(bad_csum ? 1 : -1);
  endtask

  initial begin
    int lat;
    #800000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, l, k, kind;
    logic [7:0] j;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_pkt_ok", pkt_ok, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(2);

    // Basic good frame, first beat on the cycle after the checksum byte.
    fq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    exp_ev.push_back(-1);
    exp_beats = {9'h011, 9'h022, 9'h133};
    send_fq(0);
    chk("t1_pkt_ok_timing", pkt_ok, 1);
    chk("t1_m_valid_timing", m_valid, 1);
    chk("t1_first_data", m_data, 8'h11);
    wait_drain();

    // Checksum error, then recovery with a one-byte packet.
    fq = {8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
    exp_ev.push_back(1);
    send_fq(0);
    chk("t2_pkt_err", pkt_err, 1);
    chk("t2_code", err_code, 1);
    chk("t2_busy", busy, 0);
    fq = {8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev.push_back(-1);
    exp_beats.push_back(9'h17E);
    send_fq(0);
    wait_drain();

    // Length boundaries: 17 and 0 rejected, flagged on the cycle after LEN.
    fq = {8'hA5, 8'h11};
    exp_ev.push_back(0);
    send_fq(0);
    chk("t3_len17_err", pkt_err, 1);
    chk("t3_len17_code", err_code, 0);
    chk("t3_len17_busy", busy, 0);
    idle(2);
    fq = {8'hA5, 8'h00};
    exp_ev.push_back(0);
    send_fq(0);
    chk("t3_len0_err", pkt_err, 1);
    chk("t3_len0_code", err_code, 0);
    chk("t3_len0_busy", busy, 0);
    wait_drain();

    // Timeout latency, then a byte landing on the expiry cycle.
    fq = {8'hA5, 8'h02, 8'h10};
    exp_ev.push_back(2);
    send_fq(0);
    lat = -1;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk); #1;
      if (pkt_err) begin lat = i; break; end
    end
    chk("t4_timeout_latency", lat, TMO);
    chk("t4_timeout_code", err_code, 2);
    wait_drain();
    fq = {8'hA5, 8'h02, 8'h10};
    exp_ev.push_back(-1);
    exp_beats = {9'h010, 9'h120};
    send_fq(0);
    idle(TMO - 1);
    send_byte(8'h20);
    chk("t4_expiry_byte_busy", busy, 1);
    chk("t4_expiry_byte_no_err", pkt_err, 0);
    send_byte(8'h32);
    wait_drain();

    // Overrun during a stalled stream.
    rdy_mode = 2;
    fq = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    exp_ev = {-1, 3};
    exp_beats = {9'h011, 9'h022, 9'h133};
    send_fq(0);
    send_byte(8'h5A);
    chk("t5_overrun_err", pkt_err, 1);
    chk("t5_overrun_code", err_code, 3);
    wait_drain();

    // Reset mid-frame discards silently.
    rdy_mode = 1;
    fq = {8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11};
    send_fq(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_no_err_after_rst", pkt_err, 0);
    idle(1);
    chk("t6_no_err_later", pkt_err, 0);
    fq = {8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_ev.push_back(-1);
    exp_beats.push_back(9'h17E);
    send_fq(0);
    wait_drain();

    // Randomized frames with junk prefixes, gaps and random backpressure.
    rdy_mode = 0;
    for (int f = 0; f < 40; f++) begin
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h00;
        send_byte(j);
      end
      kind = $urandom_range(0, 5);
      l = $urandom_range(1, MAXL);
      case (kind)
        3: build_frame(l, 1'b1);
        4: begin
          fq = {8'hA5, ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255))};
          exp_ev.push_back(0);
        end
        5: begin
          fq = {8'hA5, 8'(l)};
          k = $urandom_range(0, l);
          for (int i = 0; i < k; i++) fq.push_back(8'($urandom_range(0, 255)));
          exp_ev.push_back(2);
        end
        default: build_frame(l, 1'b0);
      endcase
      send_fq(4);
      wait_drain();
    end

    chk("final_beats_empty", exp_beats.size(), 0);
    chk("final_events_empty", exp_ev.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
